// File: rtl/exc_pipe_ctrl.sv
// exc_pipe_ctrl -- exception and hazard sequencer for the 5-stage MIPS pipeline.
//
// This block drives the EN/CLR controls of every pipeline register. That
// includes the WriteBack-to-Fetch PC register. It also selects the next-PC
// source, ranks stage exceptions, interrupts and ERET, and records EPC/Cause.
// The load-use stall request from the hazard unit is merged in here.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall_req           load-use stall request from the hazard unit
//   exc_ri_D, eret_D    reserved instruction / ERET in Decode
//   exc_ovf_E           arithmetic overflow in Execute
//   exc_adel_M          misaligned load address in Memory
//   irq                 external interrupt (level)
//   pc_D, pc_E, pc_M    PC of the instruction in each stage
//   en_pc, en_FD        enables of the PC register and the F/D register
//   clr_FD..clr_MW      synchronous clears of each pipeline register
//   pc_sel              00 sequential, 01 exc_vector, 10 epc
//   exc_vector          constant handler address
//   epc, cause, exl     exception PC, ExcCode of the last event, exception level
//   exc_count           (EXC_COUNT_EN only) saturating count of taken exceptions
//
// Optional feature macro: EXC_COUNT_EN adds the exc_count output and its counter.
module exc_pipe_ctrl #(
  parameter int                  WIDTH_32   = 32,
  parameter logic [WIDTH_32-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_req,
  input  logic                exc_ri_D,
  input  logic                eret_D,
  input  logic                exc_ovf_E,
  input  logic                exc_adel_M,
  input  logic                irq,
  input  logic [WIDTH_32-1:0] pc_D,
  input  logic [WIDTH_32-1:0] pc_E,
  input  logic [WIDTH_32-1:0] pc_M,
  output logic                en_pc,
  output logic                en_FD,
  output logic                clr_FD,
  output logic                clr_DE,
  output logic                clr_EM,
  output logic                clr_MW,
  output logic [1:0]          pc_sel,
  output logic [WIDTH_32-1:0] exc_vector,
`ifdef EXC_COUNT_EN
  output logic [15:0]         exc_count,
`endif
  output logic [WIDTH_32-1:0] epc,
  output logic [4:0]          cause,
  output logic                exl
);

  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WIDTH_32-1:0] epc_q, epc_d;
  logic [4:0]          cause_q, cause_d;
  logic                exl_q, exl_d;
  logic                take_exc;
  logic                irq_ok;

  assign exc_vector = EXC_VECTOR;
  assign epc        = epc_q;
  assign cause      = cause_q;
  assign exl        = exl_q;

  always_comb begin
    en_pc    = 1'b1;
    en_FD    = 1'b1;
    clr_FD   = 1'b0;
    clr_DE   = 1'b0;
    clr_EM   = 1'b0;
    clr_MW   = 1'b0;
    pc_sel   = 2'b00;
    state_d  = RUN;
    epc_d    = epc_q;
    cause_d  = cause_q;
    exl_d    = exl_q;
    take_exc = 1'b0;
    // An interrupt waits while the core is in the handler. It also waits
    // during a stall, so the interlocked instruction is never split.
    irq_ok   = irq & ~exl_q & ~stall_req;

    if (state_q == RUN) begin
      // Oldest stage first: a fault further down the pipe wins.
      if (exc_adel_M) begin
        {clr_FD, clr_DE, clr_EM, clr_MW} = 4'b1111;
        pc_sel   = 2'b01;
        epc_d    = pc_M;
        cause_d  = 5'd4;
        take_exc = 1'b1;
      end else if (exc_ovf_E) begin
        {clr_FD, clr_DE, clr_EM} = 3'b111;
        pc_sel   = 2'b01;
        epc_d    = pc_E;
        cause_d  = 5'd12;
        take_exc = 1'b1;
      end else if (exc_ri_D) begin
        {clr_FD, clr_DE} = 2'b11;
        pc_sel   = 2'b01;
        epc_d    = pc_D;
        cause_d  = 5'd10;
        take_exc = 1'b1;
      end else if (irq_ok) begin
        {clr_FD, clr_DE} = 2'b11;
        pc_sel   = 2'b01;
        epc_d    = pc_D;
        cause_d  = 5'd0;
        take_exc = 1'b1;
      end else if (eret_D && exl_q) begin
        // ERET outside the handler falls through as a NOP.
        {clr_FD, clr_DE} = 2'b11;
        pc_sel   = 2'b10;
        exl_d    = 1'b0;
        state_d  = LOCK;
      end else if (stall_req) begin
        en_pc  = 1'b0;
        en_FD  = 1'b0;
        clr_DE = 1'b1;
      end
      if (take_exc) begin
        exl_d   = 1'b1;
        state_d = LOCK;
      end
    end else begin
      // LOCK covers the cycle after a redirect. Events seen here come from
      // flushed or wrong-path instructions, so only the stall is honoured.
      if (stall_req) begin
        en_pc  = 1'b0;
        en_FD  = 1'b0;
        clr_DE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
    end
  end

`ifdef EXC_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (take_exc && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign exc_count = count_q;
`endif

endmodule

// File: doc/exc_pipe_ctrl.md
Name: exc_pipe_ctrl

Overview:
Exception and hazard sequencer for the 5-stage MIPS pipeline. It drives the EN/CLR controls of every pipeline register, including the WriteBack-to-Fetch PC register, and selects the next-PC source. It prioritises stage exceptions, interrupts and ERET, flushes the correct pipeline stages, and records EPC/Cause. It sits beside the hazard unit and merges that unit's stall request with exception handling.

Parameters:
WIDTH_32, 32, address/data width
EXC_VECTOR, 32'h0000_0080, handler fetch address

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
stall_req  in  1  load-use stall from hazard unit
exc_ri_D  in  1  reserved instruction in Decode
eret_D  in  1  ERET in Decode
exc_ovf_E  in  1  arithmetic overflow in Execute
exc_adel_M  in  1  misaligned load address in Memory
irq  in  1  external interrupt, level
pc_D, pc_E, pc_M  in  WIDTH_32  PC of instruction in each stage
en_pc  out  1  EN of the WriteBack-to-Fetch PC register
en_FD  out  1  EN of the Fetch/Decode register
clr_FD, clr_DE, clr_EM, clr_MW  out  1  CLR of each pipeline register
pc_sel  out  2  00 sequential, 01 EXC_VECTOR, 10 epc
exc_vector  out  WIDTH_32  constant EXC_VECTOR
epc  out  WIDTH_32  exception PC register
cause  out  5  ExcCode of last taken event
exl  out  1  exception level, 1 = in handler

Behaviour:
- FSM states: RUN and LOCK. Control outputs are combinational from the state and current inputs. epc, cause, exl and the state update on the clk edge.
- Reset (synchronous, rst=1 at edge): state=RUN, epc=0, cause=0, exl=0.
- Default outputs in RUN: en_pc=1, en_FD=1, all clr=0, pc_sel=00.
- Event priority in RUN, oldest instruction first: adel_M > ovf_E > ri_D > irq > eret_D > stall_req.
- adel_M taken: clr_FD/DE/EM/MW=1, pc_sel=01, epc<=pc_M, cause<=5'd4.
- ovf_E taken: clr_FD/DE/EM=1, clr_MW=0, pc_sel=01, epc<=pc_E, cause<=5'd12.
- ri_D taken: clr_FD/DE=1, pc_sel=01, epc<=pc_D, cause<=5'd10.
- irq taken only when exl=0 and stall_req=0. Same flush as ri_D, epc<=pc_D, cause<=5'd0. Otherwise irq stays pending with no side effects.
- For any exception taken: en_pc=1, en_FD=1, exl<=1, state<=LOCK.
- Synchronous exceptions (adel/ovf/ri) are taken even when exl=1 (nested); epc is overwritten.
- eret_D with no exception pending: pc_sel=10, clr_FD=1, clr_DE=1, exl<=0, state<=LOCK. ERET while exl=0 is treated as a NOP (no redirect).
- stall_req with no exception/eret: en_pc=0, en_FD=0, clr_DE=1 (bubble), other clr=0.
- Exceptions always override stall_req; the stall is discarded because the stalled instruction is flushed.
- LOCK lasts exactly 1 cycle, then RUN. In LOCK all exception, irq and eret inputs are ignored (they belong to flushed bubbles or the wrong path). stall_req is honoured as in RUN. epc, cause and exl hold.
- Latency: redirect and flush happen in the same cycle as detection; the PC register captures the new PC at that edge.
- rst asserted mid-sequence (including in LOCK) returns to RUN at the next edge with the reset values above.

Optional Feature:
EXC_COUNT_EN
- Defined: adds output exc_count [15:0]. Increments by 1 on each taken exception, not on eret or stall. Saturates at 16'hFFFF. Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle -> en_pc=1, en_FD=1, all clr=0, pc_sel=00, epc=0, cause=0, exl=0.
- stall_req=1 for 2 cycles -> en_pc=0, en_FD=0, clr_DE=1 each cycle. Normal flow resumes the cycle after stall_req=0.
- exc_ovf_E=1 with pc_E=0x0000_0040, same cycle exc_ri_D=1 and stall_req=1 -> clr_FD/DE/EM=1, clr_MW=0, pc_sel=01, en_pc=1. Next edge: epc=0x40, cause=12, exl=1. exc_ri_D pulsed in the following (LOCK) cycle -> ignored.
- exc_adel_M=1 with pc_M=0x0000_0100 while exl=1 -> all four clr=1, epc=0x100, cause=4.
- irq=1 while exl=1 -> no action. Then eret_D=1 -> pc_sel=10, clr_FD=clr_DE=1, exl=0. Cycle after LOCK, with irq still 1 and stall_req=0 and pc_D=0x0000_0200 -> epc=0x200, cause=0. With irq=1 and stall_req=1 -> not taken until stall_req falls.
- EXC_COUNT_EN defined: 3 taken exceptions -> exc_count=3. Forced to 16'hFFFF then 1 more -> stays 16'hFFFF. rst -> 0.
